spi_packet_receiver: RTL and testbench
======================================

Name: spi_packet_receiver

Overview:
- Fully synchronous SPI slave receiver (mode 0, MSB first) and command parser in the `clock` domain; replaces the sck-clocked byte reader/parser pair.
- Oversamples `cs`/`sck`/`mosi`, assembles bytes, decodes "send sprite" and "draw sprite" packets.
- Emits sprite RAM write strobes and a held draw-request handshake toward the renderer.
- Parametrised in sprite count, sprite size and synchronizer depth; adds error reporting and abort-on-`cs` recovery.

Parameters:
SPRITE_NUM, 16, number of sprite slots; sprite_select width is $clog2(SPRITE_NUM)
SPRITE_BYTES, 512, pixel bytes per "send sprite" payload (excluding the id byte)
SPRITE_ADDR_W, 10, width of sprite_w_addr; must satisfy 2**SPRITE_ADDR_W >= SPRITE_BYTES
SYNC_STAGES, 2, flip-flop stages on cs, sck and mosi (minimum 2)

Ports:
clock  input  1  system clock; must be at least 4x the sck frequency
reset  input  1  synchronous, active-high reset
cs  input  1  SPI chip select, active low, asynchronous
sck  input  1  SPI serial clock, asynchronous
mosi  input  1  SPI data in, asynchronous
miso  output  1  tied 0 (no readback in this generation)
sprite_select  output  $clog2(SPRITE_NUM)  sprite slot for the current write burst
sprite_w_en  output  1  one-cycle write strobe
sprite_w_addr  output  SPRITE_ADDR_W  byte address within the sprite, 0-based
sprite_w_data  output  8  pixel byte
draw_valid  output  1  draw request pending
draw_ready  input  1  renderer accepts the draw request
draw_sprite  output  8  sprite id of the draw request
draw_x  output  16  x coordinate
draw_y  output  16  y coordinate
draw_flags  output  8  flags byte
draw_overrun  output  1  sticky; a draw was overwritten while pending; cleared by reset only
frame_error  output  1  one-cycle pulse on a protocol error

Behaviour:
- Reset: all outputs 0, parser in CMD, bit counter 0, synchronizers cleared to idle (cs=1, sck=0).
- Synchronizers: cs, sck and mosi each pass through SYNC_STAGES flops. An sck rise is detected when synced sck is 1 and its previous value was 0, with synced cs = 0.
- Bit sampling: on an sck rise, shift synced mosi in MSB first and increment a 3-bit counter. On wrap to 0, byte_valid pulses for 1 cycle.
- Latency: sprite_w_en is high exactly 1 cycle after the byte_valid cycle.
- cs deassert (synced rising edge):
  - Bit counter clears and any partial byte is discarded.
  - Parser returns to CMD.
  - frame_error pulses if the counter was non-zero or the parser was not in CMD.
  - Any draw already committed stays valid.
- Parser states:
  - CMD: 0x00 -> SPRITE_ID; 0x01 -> DRAW_ARGS with arg index 0; any other value is ignored and the parser stays in CMD (no error).
  - SPRITE_ID: the byte is latched into sprite_select (truncated) and the write address resets to 0. If the id is >= SPRITE_NUM, the burst is marked invalid and frame_error pulses once. Next state is SPRITE_DATA.
  - SPRITE_DATA: each byte produces sprite_w_en=1 for 1 cycle with the current address and data (suppressed if the burst is invalid). The address then increments by 1. After the SPRITE_BYTES-th byte, the parser returns to CMD; the address never wraps within a burst.
  - DRAW_ARGS: 6 bytes in this order: sprite id, x[15:8], x[7:0], y[15:8], y[7:0], flags. On the 6th byte, the fields are committed to the draw_* outputs and draw_valid is set to 1; the parser returns to CMD.
- Draw handshake:
  - draw_valid and draw_* stay stable until a cycle with draw_valid & draw_ready; draw_valid clears the next cycle.
  - If a commit occurs while draw_valid=1 and draw_ready=0, the new values overwrite the old ones, draw_valid stays 1, and draw_overrun is set.
  - A commit in the same cycle as an accept leaves draw_valid=1 with the new values; no overrun.
- Reset mid-packet: reset has priority over every other event.

Test Plan:
- Send 0x00, 0x03, then SPRITE_BYTES bytes 0x00..0xFF repeating -> 512 sprite_w_en pulses, sprite_select=3, addr 0..511, data = addr[7:0], frame_error never asserted, parser back in CMD.
- Send 0x01, 0x05, 0x01, 0x40, 0x00, 0xF0, 0x80 with draw_ready=0 -> draw_valid=1, draw_sprite=5, draw_x=0x0140, draw_y=0x00F0, draw_flags=0x80. Raise draw_ready for 1 cycle -> draw_valid=0 the next cycle.
- Two draw packets back to back with draw_ready=0 -> second packet's values on the outputs, draw_overrun=1.
- Send 0x00, 0x07, 10 pixel bytes, then raise cs mid-byte after 4 bits -> 10 writes, 1 frame_error pulse. A new cs frame with 0x01 plus 6 args is then parsed correctly.
- Send 0x00, sprite id 0x20 (SPRITE_NUM=16), then 512 bytes -> 1 frame_error pulse, zero sprite_w_en pulses, parser back in CMD.
- Send 0xAA, then a valid draw packet, with sck at clock/4 and random phase -> 0xAA ignored with no error, draw fields correct. Asserting reset mid-packet forces all outputs to 0 the next cycle.

Source files
------------

// File: rtl/spi_packet_receiver.sv
`default_nettype none
// ============================================================================
// Module      : spi_packet_receiver
// Description : Oversampled SPI mode-0 slave with sprite upload / draw parser.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_packet_receiver #(
    parameter int SPRITE_NUM    = 16,
    parameter int SPRITE_BYTES  = 512,
    parameter int SPRITE_ADDR_W = 10,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          cs,
    input  logic                          sck,
    input  logic                          mosi,
    output logic                          miso,
    output logic [$clog2(SPRITE_NUM)-1:0] sprite_select,
    output logic                          sprite_w_en,
    output logic [SPRITE_ADDR_W-1:0]      sprite_w_addr,
    output logic [7:0]                    sprite_w_data,
    output logic                          draw_valid,
    input  logic                          draw_ready,
    output logic [7:0]                    draw_sprite,
    output logic [15:0]                   draw_x,
    output logic [15:0]                   draw_y,
    output logic [7:0]                    draw_flags,
    output logic                          draw_overrun,
    output logic                          frame_error
);

    localparam int                       c_SEL_W      = $clog2(SPRITE_NUM);
    localparam int unsigned              c_SPRITE_NUM = SPRITE_NUM;
    localparam logic [SPRITE_ADDR_W-1:0] c_LAST_ADDR  = SPRITE_ADDR_W'(SPRITE_BYTES - 1);

    localparam logic [1:0] c_ST_CMD         = 2'd0;
    localparam logic [1:0] c_ST_SPRITE_ID   = 2'd1;
    localparam logic [1:0] c_ST_SPRITE_DATA = 2'd2;
    localparam logic [1:0] c_ST_DRAW_ARGS   = 2'd3;

    localparam logic [7:0] c_CMD_SEND_SPRITE = 8'h00;
    localparam logic [7:0] c_CMD_DRAW_SPRITE = 8'h01;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_cs_prev;
    logic                   r_sck_prev;
    logic                   w_cs_s;
    logic                   w_sck_s;
    logic                   w_mosi_s;
    logic                   w_sck_rise;
    logic                   w_cs_rise;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cs_sync   <= '1;
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_cs_prev   <= 1'b1;
            r_sck_prev  <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_cs_prev   <= w_cs_s;
            r_sck_prev  <= w_sck_s;
        end
    end

    assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck_s & ~r_sck_prev & ~w_cs_s;
    assign w_cs_rise  = w_cs_s & ~r_cs_prev;

    // ------------------------------------------------------------------
    // Bit assembly
    // ------------------------------------------------------------------
    logic [6:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic       r_byte_valid;
    logic [7:0] r_byte;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_byte_valid <= 1'b0;
            r_byte       <= '0;
        end else begin
            r_byte_valid <= 1'b0;
            if (w_cs_rise) begin
                r_bit_cnt <= '0;
            end else if (w_sck_rise) begin
                r_shift   <= {r_shift[5:0], w_mosi_s};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_byte_valid <= 1'b1;
                    r_byte       <= {r_shift, w_mosi_s};
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Packet parser, sprite write port and draw handshake
    // ------------------------------------------------------------------
    logic [1:0]               r_state;
    logic [SPRITE_ADDR_W-1:0] r_addr;
    logic                     r_burst_invalid;
    logic [2:0]               r_arg_idx;
    logic [7:0]               r_arg_sprite;
    logic [7:0]               r_arg_x_hi;
    logic [7:0]               r_arg_x_lo;
    logic [7:0]               r_arg_y_hi;
    logic [7:0]               r_arg_y_lo;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= c_ST_CMD;
            r_addr          <= '0;
            r_burst_invalid <= 1'b0;
            r_arg_idx       <= '0;
            r_arg_sprite    <= '0;
            r_arg_x_hi      <= '0;
            r_arg_x_lo      <= '0;
            r_arg_y_hi      <= '0;
            r_arg_y_lo      <= '0;
            sprite_select   <= '0;
            sprite_w_en     <= 1'b0;
            sprite_w_addr   <= '0;
            sprite_w_data   <= '0;
            draw_valid      <= 1'b0;
            draw_sprite     <= '0;
            draw_x          <= '0;
            draw_y          <= '0;
            draw_flags      <= '0;
            draw_overrun    <= 1'b0;
            frame_error     <= 1'b0;
        end else begin
            sprite_w_en <= 1'b0;
            frame_error <= 1'b0;

            // An accept retires the request; a commit below in the same cycle wins.
            if (draw_valid && draw_ready) begin
                draw_valid <= 1'b0;
            end

            if (w_cs_rise) begin
                r_state <= c_ST_CMD;
                if ((r_bit_cnt != 3'd0) || (r_state != c_ST_CMD)) begin
                    frame_error <= 1'b1;
                end
            end else if (r_byte_valid) begin
                case (r_state)
                    c_ST_CMD: begin
                        if (r_byte == c_CMD_SEND_SPRITE) begin
                            r_state <= c_ST_SPRITE_ID;
                        end else if (r_byte == c_CMD_DRAW_SPRITE) begin
                            r_state   <= c_ST_DRAW_ARGS;
                            r_arg_idx <= '0;
                        end
                    end

                    c_ST_SPRITE_ID: begin
                        sprite_select <= r_byte[c_SEL_W-1:0];
                        r_addr        <= '0;
                        if ({24'd0, r_byte} >= c_SPRITE_NUM) begin
                            r_burst_invalid <= 1'b1;
                            frame_error     <= 1'b1;
                        end else begin
                            r_burst_invalid <= 1'b0;
                        end
                        r_state <= c_ST_SPRITE_DATA;
                    end

                    c_ST_SPRITE_DATA: begin
                        sprite_w_en   <= ~r_burst_invalid;
                        sprite_w_addr <= r_addr;
                        sprite_w_data <= r_byte;
                        r_addr        <= r_addr + 1'b1;
                        if (r_addr == c_LAST_ADDR) begin
                            r_state <= c_ST_CMD;
                        end
                    end

                    c_ST_DRAW_ARGS: begin
                        r_arg_idx <= r_arg_idx + 3'd1;
                        case (r_arg_idx)
                            3'd0: r_arg_sprite <= r_byte;
                            3'd1: r_arg_x_hi   <= r_byte;
                            3'd2: r_arg_x_lo   <= r_byte;
                            3'd3: r_arg_y_hi   <= r_byte;
                            3'd4: r_arg_y_lo   <= r_byte;
                            default: begin
                                draw_sprite <= r_arg_sprite;
                                draw_x      <= {r_arg_x_hi, r_arg_x_lo};
                                draw_y      <= {r_arg_y_hi, r_arg_y_lo};
                                draw_flags  <= r_byte;
                                draw_valid  <= 1'b1;
                                if (draw_valid && !draw_ready) begin
                                    draw_overrun <= 1'b1;
                                end
                                r_state <= c_ST_CMD;
                            end
                        endcase
                    end

                    default: r_state <= c_ST_CMD;
                endcase
            end
        end
    end

    assign miso = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_spi_packet_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_packet_receiver
// Description : Scoreboard bench for spi_packet_receiver (sprite + draw packets).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_packet_receiver;

    localparam int SPRITE_NUM    = 16;
    localparam int SPRITE_BYTES  = 512;
    localparam int SPRITE_ADDR_W = 10;

    logic                     clock = 1'b0;
    logic                     reset = 1'b1;
    logic                     cs    = 1'b1;
    logic                     sck   = 1'b0;
    logic                     mosi  = 1'b0;
    logic                     draw_ready = 1'b0;
    logic                     miso;
    logic [3:0]               sprite_select;
    logic                     sprite_w_en;
    logic [SPRITE_ADDR_W-1:0] sprite_w_addr;
    logic [7:0]               sprite_w_data;
    logic                     draw_valid;
    logic [7:0]               draw_sprite;
    logic [15:0]              draw_x;
    logic [15:0]              draw_y;
    logic [7:0]               draw_flags;
    logic                     draw_overrun;
    logic                     frame_error;

    spi_packet_receiver #(
        .SPRITE_NUM   (SPRITE_NUM),
        .SPRITE_BYTES (SPRITE_BYTES),
        .SPRITE_ADDR_W(SPRITE_ADDR_W),
        .SYNC_STAGES  (2)
    ) u_dut (
        .clock        (clock),
        .reset        (reset),
        .cs           (cs),
        .sck          (sck),
        .mosi         (mosi),
        .miso         (miso),
        .sprite_select(sprite_select),
        .sprite_w_en  (sprite_w_en),
        .sprite_w_addr(sprite_w_addr),
        .sprite_w_data(sprite_w_data),
        .draw_valid   (draw_valid),
        .draw_ready   (draw_ready),
        .draw_sprite  (draw_sprite),
        .draw_x       (draw_x),
        .draw_y       (draw_y),
        .draw_flags   (draw_flags),
        .draw_overrun (draw_overrun),
        .frame_error  (frame_error)
    );

    always #5 clock = ~clock;

    int          half_period = 20;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_wr     = 0;
    int          n_ferr   = 0;
    logic [63:0] wr_q[$];
    logic [63:0] draw_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Write scoreboard and error-pulse counter
    always @(negedge clock) begin
        if (!reset && sprite_w_en) begin
            n_wr++;
            if (wr_q.size() == 0)
                check("wr_pending", 64'(wr_q.size()), 64'd1);
            else
                check("wr", 64'({sprite_select, sprite_w_addr, sprite_w_data}), wr_q.pop_front());
        end
        if (!reset && frame_error) n_ferr++;
    end

    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            #(half_period);
            sck = 1'b1;
            #(half_period);
            sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] b);
        spi_bits(b, 8);
    endtask

    task automatic cs_start();
        cs = 1'b0;
        #(2 * half_period);
    endtask

    task automatic cs_stop();
        #(half_period);
        cs = 1'b1;
        #(8 * half_period);
    endtask

    task automatic send_sprite(input logic [7:0] id, input int nbytes, input bit expect_wr);
        logic [7:0] b;
        spi_byte(8'h00);
        spi_byte(id);
        for (int i = 0; i < nbytes; i++) begin
            b = 8'(i);
            if (expect_wr) wr_q.push_back(64'({id[3:0], 10'(i), b}));
            spi_byte(b);
        end
    endtask

    task automatic send_draw(input logic [7:0] id, input logic [15:0] x, input logic [15:0] y,
                             input logic [7:0] fl);
        draw_q.push_back(64'({id, x, y, fl}));
        spi_byte(8'h01);
        spi_byte(id);
        spi_byte(x[15:8]);
        spi_byte(x[7:0]);
        spi_byte(y[15:8]);
        spi_byte(y[7:0]);
        spi_byte(fl);
    endtask

    task automatic wait_draw(input string tag);
        for (int k = 0; k < 400 && !draw_valid; k++) @(negedge clock);
        if (!draw_valid) check({tag, "_timeout"}, 64'(draw_valid), 64'd1);
    endtask

    task automatic check_draw(input string tag);
        if (draw_q.size() == 0)
            check({tag, "_pending"}, 64'(draw_q.size()), 64'd1);
        else
            check(tag, 64'({draw_sprite, draw_x, draw_y, draw_flags}), draw_q.pop_front());
    endtask

    task automatic accept(input string tag);
        @(negedge clock);
        draw_ready = 1'b1;
        @(negedge clock);
        draw_ready = 1'b0;
        check(tag, 64'(draw_valid), 64'd0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int f0;
        int w0;

        repeat (3) @(negedge clock);
        check("rst_wr", 64'({miso, sprite_select, sprite_w_en, sprite_w_addr, sprite_w_data}), 64'd0);
        check("rst_draw", 64'({draw_valid, draw_sprite, draw_x, draw_y, draw_flags,
                               draw_overrun, frame_error}), 64'd0);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        // Full sprite upload to slot 3
        cs_start();
        send_sprite(8'h03, SPRITE_BYTES, 1'b1);
        cs_stop();
        check("t1_writes", 64'(n_wr), 64'(SPRITE_BYTES));
        check("t1_queue", 64'(wr_q.size()), 64'd0);
        check("t1_ferr", 64'(n_ferr), 64'd0);

        // Single draw with renderer stalled, then accepted
        cs_start();
        send_draw(8'h05, 16'h0140, 16'h00F0, 8'h80);
        cs_stop();
        wait_draw("t2");
        check_draw("t2_fields");
        check("t2_overrun", 64'(draw_overrun), 64'd0);
        accept("t2_accept");

        // Back-to-back draws: second overwrites and flags overrun
        cs_start();
        send_draw(8'h02, 16'h1234, 16'h5678, 8'h01);
        wait_draw("t3a");
        check_draw("t3_first");
        send_draw(8'h09, 16'hABCD, 16'h0102, 8'h7E);
        cs_stop();
        check_draw("t3_second");
        check("t3_valid", 64'(draw_valid), 64'd1);
        check("t3_overrun", 64'(draw_overrun), 64'd1);
        accept("t3_accept");
        check("t3_ferr", 64'(n_ferr), 64'd0);

        // Abort a sprite burst mid-byte, then recover with a draw
        f0 = n_ferr;
        w0 = n_wr;
        cs_start();
        send_sprite(8'h07, 10, 1'b1);
        spi_bits(8'hF0, 4);
        cs_stop();
        check("t4_writes", 64'(n_wr - w0), 64'd10);
        check("t4_ferr", 64'(n_ferr - f0), 64'd1);
        cs_start();
        send_draw(8'h01, 16'h0010, 16'h0020, 8'h03);
        cs_stop();
        wait_draw("t4");
        check_draw("t4_fields");
        accept("t4_accept");
        check("t4_ferr_after", 64'(n_ferr - f0), 64'd1);

        // Out-of-range sprite id: one error, no writes
        f0 = n_ferr;
        w0 = n_wr;
        cs_start();
        send_sprite(8'h20, SPRITE_BYTES, 1'b0);
        cs_stop();
        check("t5_writes", 64'(n_wr - w0), 64'd0);
        check("t5_ferr", 64'(n_ferr - f0), 64'd1);
        check("t5_select", 64'(sprite_select), 64'd0);

        // Unknown command ignored, random sck phase
        f0 = n_ferr;
        #($urandom_range(1, 37));
        cs_start();
        spi_byte(8'hAA);
        send_draw(8'h0C, 16'hFFFF, 16'h8001, 8'h55);
        cs_stop();
        wait_draw("t6");
        check_draw("t6_fields");
        check("t6_ferr", 64'(n_ferr - f0), 64'd0);
        accept("t6_accept");

        // Reset in the middle of a packet with a draw pending
        cs_start();
        send_draw(8'h04, 16'h0A0B, 16'h0C0D, 8'h0E);
        wait_draw("t7");
        check_draw("t7_fields");
        spi_byte(8'h01);
        spi_byte(8'h03);
        spi_bits(8'h55, 3);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("t7_rst_draw", 64'({draw_valid, draw_sprite, draw_x, draw_y, draw_flags,
                                  draw_overrun, frame_error}), 64'd0);
        check("t7_rst_wr", 64'({miso, sprite_select, sprite_w_en, sprite_w_addr, sprite_w_data}), 64'd0);
        cs  = 1'b1;
        sck = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        // Clean packet after reset
        f0 = n_ferr;
        cs_start();
        send_draw(8'h06, 16'h0102, 16'h0304, 8'h05);
        cs_stop();
        wait_draw("t8");
        check_draw("t8_fields");
        check("t8_ferr", 64'(n_ferr - f0), 64'd0);
        check("t8_overrun", 64'(draw_overrun), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
